itch_msg_controller: RTL and testbench
======================================

# itch_msg_controller

Sequencing controller for the ITCH ingress byte stream, sitting between the MAC byte interface and the order-book datapath. Frames each message as a 1-byte type, a 2-byte big-endian payload length, then the payload. It dispatches the type speculatively on the first byte and forwards payload bytes as they arrive. Each message ends with exactly one `commit` pulse, or one `abort` pulse, so downstream logic knows whether to keep or discard its speculative buffer.

## Interface
- `MAX_LEN`, 64: largest legal payload length in bytes, range 1..65535.
- `TIMEOUT`, 255: idle-gap limit in cycles inside a message, range 1..65535.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid this cycle; no backpressure.
- `spec_start`  out  1  one-cycle pulse, a type byte was accepted.
- `spec_type`  out  8  type of the current message, held until the next `spec_start`.
- `msg_len`  out  16  payload length, valid from the cycle after the low length byte until the next `spec_start`.
- `payload_data`  out  8  forwarded payload byte.
- `payload_valid`  out  1  `payload_data` valid.
- `commit`  out  1  one-cycle pulse, message complete and accepted.
- `abort`  out  1  one-cycle pulse, discard the speculative message.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LEN_HI, LEN_LO, PAYLOAD, DRAIN.
- Bytes are consumed only when `rx_valid` = 1.
- **IDLE**
  - A byte is latched as the type and `spec_start` pulses.
  - Next state is LEN_HI.
- **LEN_HI**
  - The byte is stored as `len[15:8]`.
  - Next state is LEN_LO.
- **LEN_LO**
  - Form `len = {hi, byte}` and update `msg_len`.
  - If `len` = 0: `abort` pulses and the state goes to IDLE.
  - Else if `len` > `MAX_LEN` or the type is rejected (see Configuration): `abort` pulses, the remaining counter is loaded with `len`, and the state goes to DRAIN.
  - Otherwise the remaining counter is loaded with `len` and the state goes to PAYLOAD.
- **PAYLOAD**
  - Each byte is forwarded and the 16-bit remaining counter decrements.
  - When the last byte is forwarded (remaining = 1 on acceptance), `commit` pulses and the state goes to IDLE.
- **DRAIN**
  - Bytes are discarded with no `payload_valid`.
  - When remaining = 1 on acceptance, the state goes to IDLE with no pulse; the message was already aborted.
- **Gap timer (16-bit)**
  - Cleared on every accepted byte and in IDLE.
  - Increments in other states while `rx_valid` = 0.
  - When it reaches `TIMEOUT`, the state goes to IDLE; `abort` pulses unless the state was DRAIN.
- Each message produces at most one of `commit`/`abort`; they are never high together.
- An accepted byte in the same cycle as timer expiry takes priority: the byte is processed and the timer clears.
- The counter never wraps: `len` ≥ 1 is guaranteed on load.

## Timing
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE.
- `spec_start` and `spec_type` appear 1 cycle after the type byte is accepted.
- `payload_valid`/`payload_data` appear 1 cycle after each payload byte is accepted.
- `commit` is coincident with the last `payload_valid`.
- `abort` appears 1 cycle after the low length byte is accepted, or 1 cycle after the timer reaches `TIMEOUT`.
- `busy` rises 1 cycle after the type byte is accepted and falls 1 cycle after the last byte is accepted or the timeout occurs.
- Back-to-back messages are supported at full rate: the type byte of message N+1 may follow the last payload byte of message N in the next cycle.
- Asserting `rst_n` low mid-message clears all outputs immediately. No `abort` is emitted; downstream treats reset as a global discard.

## Configuration
- `ITCH_TYPE_CHECK_EN` defined:
  - The type is accepted only if it is 0x41, 0x44, 0x45, 0x50, 0x55 or 0x58.
  - Any other type is rejected; the LEN_LO rule then aborts and drains the message.
- Not defined: every type byte is accepted.
- `spec_start` pulses for every type byte in both builds.

## Test plan
- Message 0x41, 0x00, 0x03, AA BB CC at full rate:
  - `spec_start` pulses with `spec_type` = 0x41.
  - `msg_len` = 3.
  - Three `payload_valid` beats AA/BB/CC, with `commit` on the CC beat.
  - `abort` never asserts.
- Two 1-byte messages back-to-back with no gap: two `spec_start`s and two `commit`s, and `busy` drops for at most 1 cycle between them.
- Length 0x0041 with `MAX_LEN` = 64:
  - `abort` 1 cycle after the low length byte.
  - 65 bytes are drained with no `payload_valid`.
  - A following valid message commits normally.
- Length 0x0000: `abort` pulses and the next byte is treated as a type byte.
- Stall with `TIMEOUT` = 4: after header plus 1 payload byte, `rx_valid` is held low 4 cycles → `abort`, `busy` = 0; an accepted byte in the 4th gap cycle instead continues the message.
- With `ITCH_TYPE_CHECK_EN`: type 0x5A, len 2 → `abort` and 2 bytes drained. Without the macro the same input commits.
- Reset mid-payload: `rst_n` pulsed low → outputs clear asynchronously, and the next byte is parsed as a type byte.

Source files
------------

// File: rtl/itch_msg_controller_if.sv
// -----------------------------------------------------------------------------
// itch_msg_controller_if
//
// Purpose: bundles the ITCH ingress byte stream and the sequencing outputs
// that the controller presents to the order-book datapath.
//
// Signals:
//   rx_data       [7:0]  stream byte from the MAC byte interface
//   rx_valid             rx_data valid this cycle (no backpressure)
//   spec_start           one-cycle pulse, a type byte was accepted
//   spec_type     [7:0]  type of the current message
//   msg_len      [15:0]  payload length of the current message
//   payload_data  [7:0]  forwarded payload byte
//   payload_valid        payload_data valid
//   commit               one-cycle pulse, message complete and accepted
//   abort                one-cycle pulse, discard the speculative message
//   busy                 controller is inside a message
//
// Modports:
//   master : stream source / result sink (drives rx_*, observes results)
//   slave  : the controller (observes rx_*, drives results)
// -----------------------------------------------------------------------------
interface itch_msg_controller_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        spec_start;
  logic [7:0]  spec_type;
  logic [15:0] msg_len;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        commit;
  logic        abort;
  logic        busy;

  modport master (
    output rx_data,
    output rx_valid,
    input  spec_start,
    input  spec_type,
    input  msg_len,
    input  payload_data,
    input  payload_valid,
    input  commit,
    input  abort,
    input  busy
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output spec_start,
    output spec_type,
    output msg_len,
    output payload_data,
    output payload_valid,
    output commit,
    output abort,
    output busy
  );
endinterface

// File: rtl/itch_msg_controller.sv
// -----------------------------------------------------------------------------
// itch_msg_controller
//
// Purpose: sequencing controller for the ITCH ingress byte stream. Each message
// is a 1-byte type, a 2-byte big-endian payload length, then the payload. The
// type is dispatched speculatively on the first byte, payload bytes are
// forwarded as they arrive, and every message ends with exactly one commit or
// one abort pulse (or, when already aborted, nothing further).
//
// Parameters:
//   MAX_LEN  largest legal payload length in bytes (1..65535)
//   TIMEOUT  idle-gap limit in cycles inside a message (1..65535)
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset; clears every output immediately
//   bus    itch_msg_controller_if.slave (stream in, sequencing results out)
//
// Build option:
//   ITCH_TYPE_CHECK_EN  when defined, only types 0x41, 0x44, 0x45, 0x50, 0x55
//                       and 0x58 are accepted; any other type is aborted and
//                       its payload drained. When undefined every type is
//                       accepted. spec_start pulses for every type in both.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module itch_msg_controller #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  itch_msg_controller_if.slave bus
);

  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  state_e      state_r;
  logic [7:0]  len_hi_r;
  logic [15:0] rem_r;
  logic [15:0] gap_r;

  logic        spec_start_r;
  logic [7:0]  spec_type_r;
  logic [15:0] msg_len_r;
  logic [7:0]  payload_data_r;
  logic        payload_valid_r;
  logic        commit_r;
  logic        abort_r;
  logic        busy_r;

  logic [15:0] len_s;
  logic [15:0] gap_inc_s;
  logic        timeout_s;
  logic        last_s;
  logic        type_ok_s;

`ifdef ITCH_TYPE_CHECK_EN
  // Whitelist of message types the order book understands.
  function automatic logic type_accepted(input logic [7:0] msg_type);
    logic ok;
    case (msg_type)
      8'h41, 8'h44, 8'h45, 8'h50, 8'h55, 8'h58: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // spec_type_r still holds the type byte while the length bytes arrive.
  assign type_ok_s = type_accepted(spec_type_r);
`else
  assign type_ok_s = 1'b1;
`endif

  // Header length, gap-timer expiry and last-byte detection for the FSM.
  always_comb begin
    len_s     = {len_hi_r, bus.rx_data};
    gap_inc_s = gap_r + 16'd1;
    // Expiry is decided on the gap cycle that would bring the timer to
    // TIMEOUT, so the state is IDLE and abort is visible right after it.
    timeout_s = (gap_inc_s == TIMEOUT_C);
    last_s    = (rem_r == 16'd1);
  end

  // Message sequencing FSM with registered outputs and gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      len_hi_r        <= 8'd0;
      rem_r           <= 16'd0;
      gap_r           <= 16'd0;
      spec_start_r    <= 1'b0;
      spec_type_r     <= 8'd0;
      msg_len_r       <= 16'd0;
      payload_data_r  <= 8'd0;
      payload_valid_r <= 1'b0;
      commit_r        <= 1'b0;
      abort_r         <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      // Pulses default low; each is raised for a single cycle below.
      spec_start_r    <= 1'b0;
      payload_valid_r <= 1'b0;
      commit_r        <= 1'b0;
      abort_r         <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          gap_r <= 16'd0;
          if (bus.rx_valid) begin
            spec_start_r <= 1'b1;
            spec_type_r  <= bus.rx_data;
            busy_r       <= 1'b1;
            state_r      <= ST_LEN_HI;
          end else begin
            busy_r <= 1'b0;
          end
        end

        ST_LEN_HI: begin
          if (bus.rx_valid) begin
            len_hi_r <= bus.rx_data;
            gap_r    <= 16'd0;
            state_r  <= ST_LEN_LO;
          end else if (timeout_s) begin
            abort_r <= 1'b1;
            busy_r  <= 1'b0;
            gap_r   <= 16'd0;
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_inc_s;
          end
        end

        ST_LEN_LO: begin
          if (bus.rx_valid) begin
            msg_len_r <= len_s;
            gap_r     <= 16'd0;
            if (len_s == 16'd0) begin
              // Empty message: nothing to forward or drain.
              abort_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else if ((len_s > MAX_LEN_C) || !type_ok_s) begin
              // Abort now, but still swallow the payload to stay framed.
              abort_r <= 1'b1;
              rem_r   <= len_s;
              state_r <= ST_DRAIN;
            end else begin
              rem_r   <= len_s;
              state_r <= ST_PAYLOAD;
            end
          end else if (timeout_s) begin
            abort_r <= 1'b1;
            busy_r  <= 1'b0;
            gap_r   <= 16'd0;
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_inc_s;
          end
        end

        ST_PAYLOAD: begin
          if (bus.rx_valid) begin
            payload_valid_r <= 1'b1;
            payload_data_r  <= bus.rx_data;
            gap_r           <= 16'd0;
            rem_r           <= rem_r - 16'd1;
            if (last_s) begin
              // commit rides on the final payload beat.
              commit_r <= 1'b1;
              busy_r   <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              state_r <= ST_PAYLOAD;
            end
          end else if (timeout_s) begin
            abort_r <= 1'b1;
            busy_r  <= 1'b0;
            gap_r   <= 16'd0;
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_inc_s;
          end
        end

        ST_DRAIN: begin
          if (bus.rx_valid) begin
            gap_r <= 16'd0;
            rem_r <= rem_r - 16'd1;
            if (last_s) begin
              // Already aborted in LEN_LO, so leave silently.
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DRAIN;
            end
          end else if (timeout_s) begin
            // Message was already aborted; a second pulse would double-discard.
            busy_r  <= 1'b0;
            gap_r   <= 16'd0;
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_inc_s;
          end
        end

        default: begin
          busy_r  <= 1'b0;
          gap_r   <= 16'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.spec_start    = spec_start_r;
  assign bus.spec_type     = spec_type_r;
  assign bus.msg_len       = msg_len_r;
  assign bus.payload_data  = payload_data_r;
  assign bus.payload_valid = payload_valid_r;
  assign bus.commit        = commit_r;
  assign bus.abort         = abort_r;
  assign bus.busy          = busy_r;

endmodule

// File: tb/tb_itch_msg_controller.sv
// -----------------------------------------------------------------------------
// tb_itch_msg_controller
//
// Directed bench for itch_msg_controller (MAX_LEN = 64, TIMEOUT = 4). Expected
// spec_start types, payload beats (with their commit flag) and aborts are
// queued as the causing byte is driven and matched right after the clock edge
// that must produce them; anything still queued afterwards is reported missing.
// -----------------------------------------------------------------------------
module tb_itch_msg_controller;

  logic clk = 1'b0;
  logic rst_n;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_type_q[$];
  logic [8:0] exp_pay_q[$];
  int         exp_abort = 0;

  itch_msg_controller_if bus ();

  itch_msg_controller #(
    .MAX_LEN (64),
    .TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check every output event against the scoreboard.
  task automatic step(input logic v, input logic [7:0] d);
    logic [8:0] e;
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    if (bus.spec_start) begin
      if (exp_type_q.size() == 0) chk("unexpected_spec_start", 32'(bus.spec_start), 32'd0);
      else chk("spec_type", 32'(bus.spec_type), 32'(exp_type_q.pop_front()));
    end
    if (bus.payload_valid) begin
      if (exp_pay_q.size() == 0) chk("unexpected_payload", 32'(bus.payload_valid), 32'd0);
      else begin
        e = exp_pay_q.pop_front();
        chk("payload_commit_data", 32'({bus.commit, bus.payload_data}), 32'(e));
      end
    end else if (bus.commit) begin
      chk("commit_without_payload", 32'(bus.commit), 32'd0);
    end
    if (bus.abort) begin
      if (exp_abort == 0) chk("unexpected_abort", 32'(bus.abort), 32'd0);
      else exp_abort--;
      if (bus.commit) chk("commit_abort_together", 32'(bus.commit & bus.abort), 32'd0);
    end
    chk("missing_spec_start", 32'(exp_type_q.size()), 32'd0);
    chk("missing_payload", 32'(exp_pay_q.size()), 32'd0);
    chk("missing_abort", 32'(exp_abort), 32'd0);
  endtask

  task automatic send_type(input logic [7:0] t);
    exp_type_q.push_back(t);
    step(1'b1, t);
  endtask

  task automatic send_len(input logic [15:0] len, input logic expect_abort);
    step(1'b1, len[15:8]);
    if (expect_abort) exp_abort++;
    step(1'b1, len[7:0]);
    chk("msg_len", 32'(bus.msg_len), 32'(len));
  endtask

  task automatic send_pay(input logic [7:0] d, input logic last);
    exp_pay_q.push_back({last, d});
    step(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n        = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_spec_start", 32'(bus.spec_start), 32'd0);
    chk("rst_spec_type", 32'(bus.spec_type), 32'd0);
    chk("rst_msg_len", 32'(bus.msg_len), 32'd0);
    chk("rst_payload_data", 32'(bus.payload_data), 32'd0);
    chk("rst_payload_valid", 32'(bus.payload_valid), 32'd0);
    chk("rst_commit", 32'(bus.commit), 32'd0);
    chk("rst_abort", 32'(bus.abort), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic message 0x41, len 3, AA BB CC
    send_type(8'h41);
    chk("busy_after_type", 32'(bus.busy), 32'd1);
    send_len(16'd3, 1'b0);
    send_pay(8'hAA, 1'b0);
    send_pay(8'hBB, 1'b0);
    send_pay(8'hCC, 1'b1);
    chk("busy_after_commit", 32'(bus.busy), 32'd0);
    idle(2);

    // Two 1-byte messages back-to-back
    send_type(8'h44);
    send_len(16'd1, 1'b0);
    send_pay(8'h11, 1'b1);
    chk("b2b_busy_gap", 32'(bus.busy), 32'd0);
    send_type(8'h45);
    chk("b2b_busy_rise", 32'(bus.busy), 32'd1);
    send_len(16'd1, 1'b0);
    send_pay(8'h22, 1'b1);
    chk("b2b_busy_end", 32'(bus.busy), 32'd0);
    idle(1);

    // Oversize length 0x0041: abort, drain 65 bytes, then a normal message
    send_type(8'h50);
    send_len(16'h0041, 1'b1);
    for (int i = 0; i < 65; i++) begin
      step(1'b1, 8'(i));
      if (i < 64) chk("drain_busy", 32'(bus.busy), 32'd1);
    end
    chk("drain_done_busy", 32'(bus.busy), 32'd0);
    send_type(8'h55);
    send_len(16'd2, 1'b0);
    send_pay(8'h01, 1'b0);
    send_pay(8'h02, 1'b1);

    // Zero length: abort, next byte is a type byte
    send_type(8'h58);
    send_len(16'd0, 1'b1);
    chk("zero_len_busy", 32'(bus.busy), 32'd0);
    send_type(8'h41);
    send_len(16'd1, 1'b0);
    send_pay(8'h77, 1'b1);

    // Stall of TIMEOUT cycles inside payload: abort
    send_type(8'h41);
    send_len(16'd2, 1'b0);
    send_pay(8'h01, 1'b0);
    idle(3);
    chk("stall_busy_before_expiry", 32'(bus.busy), 32'd1);
    exp_abort++;
    idle(1);
    chk("stall_busy_after_expiry", 32'(bus.busy), 32'd0);
    idle(2);

    // Byte on the 4th gap cycle continues the message
    send_type(8'h41);
    send_len(16'd2, 1'b0);
    send_pay(8'h01, 1'b0);
    idle(3);
    send_pay(8'h02, 1'b1);
    chk("late_byte_busy", 32'(bus.busy), 32'd0);
    idle(5);

    // Timeout while draining: silent return to IDLE
    send_type(8'h50);
    send_len(16'h0050, 1'b1);
    step(1'b1, 8'h00);
    idle(4);
    chk("drain_timeout_busy", 32'(bus.busy), 32'd0);
    idle(1);

    // Unlisted type 0x5A, len 2
    send_type(8'h5A);
`ifdef ITCH_TYPE_CHECK_EN
    send_len(16'd2, 1'b1);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
`else
    send_len(16'd2, 1'b0);
    send_pay(8'h01, 1'b0);
    send_pay(8'h02, 1'b1);
`endif
    chk("type_case_busy", 32'(bus.busy), 32'd0);

    // Reset mid-payload clears outputs asynchronously
    send_type(8'h41);
    send_len(16'd5, 1'b0);
    send_pay(8'h10, 1'b0);
    send_pay(8'h11, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("async_rst_payload_valid", 32'(bus.payload_valid), 32'd0);
    chk("async_rst_payload_data", 32'(bus.payload_data), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_spec_type", 32'(bus.spec_type), 32'd0);
    chk("async_rst_msg_len", 32'(bus.msg_len), 32'd0);
    #1;
    rst_n = 1'b1;
    send_type(8'h44);
    send_len(16'd1, 1'b0);
    send_pay(8'h99, 1'b1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
